// File: rtl/rsa_keygen_ctrl.sv
// RSA private-key derivation sequencer: computes n and phi with a bit-serial multiplier,
// validates e, runs the shared extended_euclidean engine under a watchdog and reports d.
module rsa_keygen_ctrl #(
    parameter int unsigned WIDTH   = 256,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH/2-1:0] p,
    input  logic [WIDTH/2-1:0] q,
    input  logic [WIDTH-1:0]   e,
    output logic               eu_start,
    output logic [WIDTH-1:0]   eu_e,
    output logic [WIDTH-1:0]   eu_phi,
    input  logic [WIDTH-1:0]   eu_d,
    input  logic               eu_valid,
    output logic [WIDTH-1:0]   n,
    output logic [WIDTH-1:0]   phi,
    output logic [WIDTH-1:0]   d,
    output logic               busy,
    output logic               done,
    output logic [2:0]         err_code
);

    localparam int unsigned HALF = WIDTH / 2;
    localparam int unsigned BW   = $clog2(HALF);
    localparam int unsigned TW   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle, StChkp, StMul, StChke, StEuStart, StEuWait, StFin
    } state_e;

    state_e state_q, state_d;

    logic [HALF-1:0]  p_q, q_q;
    logic [WIDTH-1:0] e_q;
    logic [WIDTH-1:0] mcand_a_q, mcand_b_q, acc_a_q, acc_b_q;
    logic [HALF-1:0]  mplier_a_q, mplier_b_q;
    logic [BW-1:0]    bit_q;
    logic [TW-1:0]    tmo_q;
    logic [WIDTH-1:0] n_q, phi_q, d_q, eu_e_q, eu_phi_q;
    logic [2:0]       err_q;

    logic             p_bad, e_bad, mul_last, tmo_hit;
    logic [WIDTH-1:0] acc_a_nxt, acc_b_nxt;

    assign p_bad     = (p_q < HALF'(2)) || (q_q < HALF'(2));
    assign e_bad     = (e_q < WIDTH'(3)) || !e_q[0] || (e_q >= phi_q);
    assign mul_last  = (bit_q == BW'(HALF - 1));
    // Counter value TIMEOUT-1 is the TIMEOUT-th waiting cycle.
    assign tmo_hit   = (tmo_q == TW'(TIMEOUT - 1));
    assign acc_a_nxt = acc_a_q + (mplier_a_q[0] ? mcand_a_q : '0);
    assign acc_b_nxt = acc_b_q + (mplier_b_q[0] ? mcand_b_q : '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (start) state_d = StChkp;
            StChkp:    state_d = p_bad ? StFin : StMul;
            StMul:     if (mul_last) state_d = StChke;
            StChke:    state_d = e_bad ? StFin : StEuStart;
            StEuStart: state_d = StEuWait;
            StEuWait:  if (eu_valid || tmo_hit) state_d = StFin;
            StFin:     state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_q        <= '0;
            q_q        <= '0;
            e_q        <= '0;
            mcand_a_q  <= '0;
            mcand_b_q  <= '0;
            mplier_a_q <= '0;
            mplier_b_q <= '0;
            acc_a_q    <= '0;
            acc_b_q    <= '0;
            bit_q      <= '0;
            tmo_q      <= '0;
            n_q        <= '0;
            phi_q      <= '0;
            d_q        <= '0;
            eu_e_q     <= '0;
            eu_phi_q   <= '0;
            err_q      <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        p_q   <= p;
                        q_q   <= q;
                        e_q   <= e;
                        err_q <= 3'd0;
                    end
                end
                StChkp: begin
                    if (p_bad) begin
                        err_q <= 3'd1;
                    end else begin
                        mcand_a_q  <= {{HALF{1'b0}}, p_q};
                        mcand_b_q  <= {{HALF{1'b0}}, p_q - HALF'(1)};
                        mplier_a_q <= q_q;
                        mplier_b_q <= q_q - HALF'(1);
                        acc_a_q    <= '0;
                        acc_b_q    <= '0;
                        bit_q      <= '0;
                    end
                end
                StMul: begin
                    acc_a_q    <= acc_a_nxt;
                    acc_b_q    <= acc_b_nxt;
                    mcand_a_q  <= mcand_a_q << 1;
                    mcand_b_q  <= mcand_b_q << 1;
                    mplier_a_q <= mplier_a_q >> 1;
                    mplier_b_q <= mplier_b_q >> 1;
                    bit_q      <= bit_q + BW'(1);
                    if (mul_last) begin
                        n_q   <= acc_a_nxt;
                        phi_q <= acc_b_nxt;
                    end
                end
                StChke: begin
                    if (e_bad) begin
                        err_q <= 3'd2;
                    end else begin
                        eu_e_q   <= e_q;
                        eu_phi_q <= phi_q;
                    end
                end
                StEuStart: tmo_q <= '0;
                StEuWait: begin
                    tmo_q <= tmo_q + TW'(1);
                    if (eu_valid) begin
                        d_q <= eu_d;
                        if (eu_d == '0) err_q <= 3'd4;
                    end else if (tmo_hit) begin
                        d_q   <= '0;
                        err_q <= 3'd3;
                    end
                end
                default: ;
            endcase
        end
    end

    assign eu_start = (state_q == StEuStart);
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StFin);
    assign eu_e     = eu_e_q;
    assign eu_phi   = eu_phi_q;
    assign n        = n_q;
    assign phi      = phi_q;
    assign d        = d_q;
    assign err_code = err_q;

endmodule

// File: tb/tb_rsa_keygen_ctrl.sv
// Scoreboard bench for rsa_keygen_ctrl with a behavioural inverse engine (normal, silent,
// zero-result modes). Expected job results are queued at start and checked on done.
module tb_rsa_keygen_ctrl;

    localparam int unsigned WIDTH   = 256;
    localparam int unsigned TIMEOUT = 64;
    localparam int          ENG_DLY = 5;
    localparam int          LAT_OK  = 131 + ENG_DLY + 1;
    localparam int          LAT_BE  = 131;
    localparam int          LAT_BP  = 2;
    localparam int          LAT_TMO = 131 + 65;

    typedef struct {
        logic [WIDTH-1:0] n;
        logic [WIDTH-1:0] phi;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] e;
        logic [2:0]       err;
        bit               chk_d;
        int               eus;
        longint           exp_cyc;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [WIDTH/2-1:0] p, q;
    logic [WIDTH-1:0]   e;
    logic               eu_start;
    logic [WIDTH-1:0]   eu_e, eu_phi, eu_d;
    logic               eu_valid;
    logic [WIDTH-1:0]   n, phi, d;
    logic               busy, done;
    logic [2:0]         err_code;

    exp_t   sb_q[$];
    exp_t   mon_x;
    exp_t   dummy;
    int     n_checks = 0;
    int     n_errors = 0;
    longint cyc = 0;
    int     eus_cnt = 0;
    int     eng_mode = 0;  // 0 normal, 1 silent, 2 returns zero
    int     eng_cnt = 0;
    logic [WIDTH-1:0] eng_e, eng_phi;
    bit     busy_chk = 1'b0;

    rsa_keygen_ctrl #(
        .WIDTH  (WIDTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .p       (p),
        .q       (q),
        .e       (e),
        .eu_start(eu_start),
        .eu_e    (eu_e),
        .eu_phi  (eu_phi),
        .eu_d    (eu_d),
        .eu_valid(eu_valid),
        .n       (n),
        .phi     (phi),
        .d       (d),
        .busy    (busy),
        .done    (done),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [WIDTH-1:0] got,
                            input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [WIDTH-1:0] nn, input logic [WIDTH-1:0] pp,
                                input logic [WIDTH-1:0] dd, input logic [WIDTH-1:0] ee,
                                input logic [2:0] er, input bit cd, input int es);
        exp_t x;
        x.n = nn; x.phi = pp; x.d = dd; x.e = ee; x.err = er;
        x.chk_d = cd; x.eus = es; x.exp_cyc = 0;
        return x;
    endfunction

    function automatic logic [WIDTH-1:0] inverse(input logic [WIDTH-1:0] ee,
                                                 input logic [WIDTH-1:0] pp);
        longint ev, ph, res;
        ev  = longint'(ee[63:0]);
        ph  = longint'(pp[63:0]);
        res = 0;
        for (longint i = 1; i < ph; i++) begin
            if ((ev * i) % ph == 1) begin
                res = i;
                break;
            end
        end
        return WIDTH'(res);
    endfunction

    // Behavioural engine: answers ENG_DLY cycles after each eu_start pulse.
    always @(negedge clk) begin
        eu_valid = 1'b0;
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0 && eng_mode != 1) begin
                eu_valid = 1'b1;
                eu_d     = (eng_mode == 2) ? '0 : inverse(eng_e, eng_phi);
            end
        end
        if (rst === 1'b1 && eu_start === 1'b1) begin
            eus_cnt++;
            eng_e   = eu_e;
            eng_phi = eu_phi;
            eng_cnt = ENG_DLY;
            if (sb_q.size() > 0) begin
                check_eq("eu_e", eu_e, sb_q[0].e);
                check_eq("eu_phi", eu_phi, sb_q[0].phi);
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (busy_chk) begin
                busy_chk = 1'b0;
                check_eq("busy_after_done", busy, 0);
            end
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_done", done, 0);
                end else begin
                    mon_x = sb_q.pop_front();
                    check_eq("n", n, mon_x.n);
                    check_eq("phi", phi, mon_x.phi);
                    check_eq("err_code", err_code, mon_x.err);
                    if (mon_x.chk_d) check_eq("d", d, mon_x.d);
                    check_eq("latency", cyc, mon_x.exp_cyc);
                    check_eq("eu_start_count", eus_cnt, mon_x.eus);
                    busy_chk = 1'b1;
                end
            end
        end
    end

    task automatic drive_job(input logic [WIDTH/2-1:0] pp, input logic [WIDTH/2-1:0] qq,
                             input logic [WIDTH-1:0] ee, input exp_t x, input int lat,
                             input bit push);
        @(negedge clk);
        p     = pp;
        q     = qq;
        e     = ee;
        start = 1'b1;
        if (push) begin
            x.exp_cyc = cyc + lat;
            eus_cnt   = 0;
            sb_q.push_back(x);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && sb_q.size() != 0; i++) @(negedge clk);
        check_eq("done_wait", sb_q.size(), 0);
    endtask

    task automatic chk_zero(input string tag);
        check_eq({tag, "_n"}, n, 0);
        check_eq({tag, "_phi"}, phi, 0);
        check_eq({tag, "_d"}, d, 0);
        check_eq({tag, "_err"}, err_code, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_eu_start"}, eu_start, 0);
        check_eq({tag, "_eu_e"}, eu_e, 0);
        check_eq({tag, "_eu_phi"}, eu_phi, 0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; p = '0; q = '0; e = '0; eu_d = '0; eu_valid = 1'b0;
        dummy = mk(0, 0, 0, 0, 3'd0, 1'b0, 0);
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;

        drive_job(61, 53, 17, mk(3233, 3120, 2753, 17, 3'd0, 1'b1, 1), LAT_OK, 1'b1);
        wait_done(400);

        drive_job(1, 53, 17, mk(3233, 3120, 0, 17, 3'd1, 1'b0, 0), LAT_BP, 1'b1);
        wait_done(50);

        drive_job(61, 53, 3120, mk(3233, 3120, 0, 3120, 3'd2, 1'b0, 0), LAT_BE, 1'b1);
        wait_done(400);
        drive_job(61, 53, 16, mk(3233, 3120, 0, 16, 3'd2, 1'b0, 0), LAT_BE, 1'b1);
        wait_done(400);
        drive_job(61, 53, 1, mk(3233, 3120, 0, 1, 3'd2, 1'b0, 0), LAT_BE, 1'b1);
        wait_done(400);

        eng_mode = 1;
        drive_job(61, 53, 17, mk(3233, 3120, 0, 17, 3'd3, 1'b1, 1), LAT_TMO, 1'b1);
        wait_done(400);
        eng_mode = 2;
        drive_job(61, 53, 17, mk(3233, 3120, 0, 17, 3'd4, 1'b1, 1), LAT_OK, 1'b1);
        wait_done(400);

        eng_mode = 0;
        drive_job(61, 53, 17, mk(3233, 3120, 2753, 17, 3'd0, 1'b1, 1), LAT_OK, 1'b1);
        repeat (20) @(negedge clk);
        drive_job(11, 13, 7, dummy, 0, 1'b0);
        wait_done(400);
        drive_job(11, 13, 7, mk(143, 120, 103, 7, 3'd0, 1'b1, 1), LAT_OK, 1'b1);
        wait_done(400);

        // Abort a job while the engine is pending.
        eng_mode = 1;
        eus_cnt  = 0;
        drive_job(61, 53, 17, dummy, 0, 1'b0);
        for (int i = 0; i < 300 && eus_cnt == 0; i++) @(negedge clk);
        check_eq("rst_eu_start_seen", eus_cnt, 1);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        chk_zero("midjob_rst");
        eng_cnt = 0;
        repeat (3) @(negedge clk);
        rst      = 1'b1;
        eng_mode = 0;
        drive_job(61, 53, 17, mk(3233, 3120, 2753, 17, 3'd0, 1'b1, 1), LAT_OK, 1'b1);
        wait_done(400);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
